seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 167 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with per-digit enables, decimal points,
// ghost-guard blanking at each slot start and a double-buffered frame of glyph codes.
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int PRESCALE       = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     dig,
    output logic                  frame_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

    function automatic logic [6:0] glyph(input logic [3:0] code);
        case (code)
            4'h0:    glyph = 7'b1111110;
            4'h1:    glyph = 7'b0110000;
            4'h2:    glyph = 7'b1101101;
            4'h3:    glyph = 7'b1111001;
            4'h4:    glyph = 7'b0110011;
            4'h5:    glyph = 7'b1011011;
            4'h6:    glyph = 7'b1011111;
            4'h7:    glyph = 7'b1110000;
            4'h8:    glyph = 7'b1111111;
            4'h9:    glyph = 7'b1111011;
            4'hA:    glyph = 7'b0000001;
            4'hB:    glyph = 7'b0001110;
            4'hC:    glyph = 7'b1001110;
            4'hD:    glyph = 7'b1000110;
            4'hE:    glyph = 7'b1001111;
            default: glyph = 7'b0000000;
        endcase
    endfunction

    logic [CW-1:0]     slot_cnt_r;
    logic [IW-1:0]     idx_r;
    logic [3:0]        act_code_r  [DIGITS];
    logic [3:0]        pend_code_r [DIGITS];
    logic [DIGITS-1:0] act_dp_r;
    logic [DIGITS-1:0] pend_dp_r;
    logic [6:0]        seg_r;
    logic              dp_r;
    logic [DIGITS-1:0] dig_r;
    logic              frame_done_r;

    logic              slot_wrap_s;
    logic              frame_wrap_s;
    logic [CW-1:0]     slot_nxt_s;
    logic [IW-1:0]     idx_nxt_s;
    logic              lit_s;
    logic [6:0]        seg_on_s;
    logic              dp_on_s;
    logic [DIGITS-1:0] dig_on_s;

    // Next slot count and digit index; everything freezes while disabled.
    always_comb begin
        slot_wrap_s  = enable && (slot_cnt_r == SLOT_LAST);
        frame_wrap_s = slot_wrap_s && (idx_r == IDX_LAST);
        slot_nxt_s   = slot_cnt_r;
        idx_nxt_s    = idx_r;
        if (!enable) begin
            slot_nxt_s = slot_cnt_r;
            idx_nxt_s  = idx_r;
        end else if (slot_wrap_s) begin
            slot_nxt_s = {CW{1'b0}};
            if (frame_wrap_s) begin
                idx_nxt_s = {IW{1'b0}};
            end else begin
                idx_nxt_s = idx_r + IW'(1'b1);
            end
        end else begin
            slot_nxt_s = slot_cnt_r + CW'(1'b1);
            idx_nxt_s  = idx_r;
        end
    end

    // Logical (active-high) display pattern for the current counter state.
    always_comb begin
        lit_s    = enable && (slot_cnt_r >= BLANK_LIM) && digit_en[idx_r];
        seg_on_s = 7'b0000000;
        dp_on_s  = 1'b0;
        dig_on_s = {DIGITS{1'b0}};
        if (lit_s) begin
            seg_on_s = glyph(act_code_r[idx_r]);
            dp_on_s  = act_dp_r[idx_r];
            dig_on_s = DIGITS'(1'b1) << idx_r;
        end else begin
            seg_on_s = 7'b0000000;
            dp_on_s  = 1'b0;
            dig_on_s = {DIGITS{1'b0}};
        end
    end

    // Slot counter and digit index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_r <= {CW{1'b0}};
            idx_r      <= {IW{1'b0}};
        end else begin
            slot_cnt_r <= slot_nxt_s;
            idx_r      <= idx_nxt_s;
        end
    end

    // Double buffer: a load landing on the frame wrap bypasses pending so newest wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DIGITS; k++) begin
                act_code_r[k]  <= 4'hF;
                pend_code_r[k] <= 4'hF;
            end
            act_dp_r  <= {DIGITS{1'b0}};
            pend_dp_r <= {DIGITS{1'b0}};
        end else begin
            if (load) begin
                for (int k = 0; k < DIGITS; k++) begin
                    pend_code_r[k] <= data[4*k +: 4];
                end
                pend_dp_r <= dp_in;
            end
            if (frame_wrap_s) begin
                for (int k = 0; k < DIGITS; k++) begin
                    act_code_r[k] <= load ? data[4*k +: 4] : pend_code_r[k];
                end
                act_dp_r <= load ? dp_in : pend_dp_r;
            end
        end
    end

    // Registered pin outputs with polarity applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r        <= {7{SEG_INV}};
            dp_r         <= SEG_INV;
            dig_r        <= {DIGITS{DIG_INV}};
            frame_done_r <= 1'b0;
        end else begin
            seg_r        <= seg_on_s ^ {7{SEG_INV}};
            dp_r         <= dp_on_s ^ SEG_INV;
            dig_r        <= dig_on_s ^ {DIGITS{DIG_INV}};
            frame_done_r <= frame_wrap_s;
        end
    end

    assign seg        = seg_r;
    assign dp         = dp_r;
    assign dig        = dig_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: active-high and active-low instances share stimulus and are
// compared every cycle against a frame-position model of the scan.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic [3:0]  digit_en = 4'b1111;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  dig_a, dig_b;
    logic        fd_a, fd_b;

    int tests = 0;
    int fails = 0;

    // Model state: t is the position inside a 32-clock frame (4 digits x 8 clocks).
    int          t = 0;
    logic [3:0]  m_pend [4] = '{4'hF, 4'hF, 4'hF, 4'hF};
    logic [3:0]  m_act  [4] = '{4'hF, 4'hF, 4'hF, 4'hF};
    logic [3:0]  m_pdp = 4'b0000;
    logic [3:0]  m_adp = 4'b0000;

    logic [6:0] glyph_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                   7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                   7'b1111111, 7'b1111011, 7'b0000001, 7'b0001110,
                                   7'b1001110, 7'b1000110, 7'b1001111, 7'b0000000};

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2),
                       .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) u_dut_hi (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .data(data),
        .dp_in(dp_in), .digit_en(digit_en),
        .seg(seg_a), .dp(dp_a), .dig(dig_a), .frame_done(fd_a));

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2),
                       .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_dut_lo (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .data(data),
        .dp_in(dp_in), .digit_en(digit_en),
        .seg(seg_b), .dp(dp_b), .dig(dig_b), .frame_done(fd_b));

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b (frame pos %0d)", name, got, exp, t);
        end
    endtask

    // One clock: expectation from pre-edge model state and inputs, check after the edge.
    task automatic cycle();
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] e_dig;
        logic       e_fd;
        int         i;
        int         c;
        e_seg = 7'b0000000;
        e_dp  = 1'b0;
        e_dig = 4'b0000;
        e_fd  = 1'b0;
        if (!rst && enable) begin
            i = t / 8;
            c = t % 8;
            if (c >= 2 && digit_en[i]) begin
                e_seg = glyph_tab[m_act[i]];
                e_dp  = m_adp[i];
                e_dig = 4'b0001 << i;
            end
            e_fd = (t == 31);
        end
        @(posedge clk);
        #1;
        check("seg",        seg_a,        e_seg);
        check("dp",         {6'b0, dp_a}, {6'b0, e_dp});
        check("dig",        {3'b0, dig_a}, {3'b0, e_dig});
        check("frame_done", {6'b0, fd_a}, {6'b0, e_fd});
        check("seg_n",      seg_b,        ~e_seg);
        check("dp_n",       {6'b0, dp_b}, {6'b0, ~e_dp});
        check("dig_n",      {3'b0, dig_b}, {3'b0, ~e_dig});
        check("frame_done_n", {6'b0, fd_b}, {6'b0, e_fd});
        if (rst) begin
            t = 0;
            for (int k = 0; k < 4; k++) begin
                m_pend[k] = 4'hF;
                m_act[k]  = 4'hF;
            end
            m_pdp = 4'b0000;
            m_adp = 4'b0000;
        end else begin
            if (load) begin
                for (int k = 0; k < 4; k++) m_pend[k] = data[4*k +: 4];
                m_pdp = dp_in;
            end
            if (enable) begin
                if (t == 31) begin
                    for (int k = 0; k < 4; k++) m_act[k] = m_pend[k];
                    m_adp = m_pdp;
                end
                t = (t + 1) % 32;
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
        data  = d;
        dp_in = p;
        load  = 1'b1;
        cycle();
        load  = 1'b0;
    endtask

    task automatic run_to(input int pos);
        for (int k = 0; k < 100 && t != pos; k++) cycle();
    endtask

    initial begin
        // Reset values, then a blank frame with no load.
        run(2);
        rst = 1'b0;
        run(40);

        // 1234 with dp on digit 0, loaded before the next wrap.
        run_to(10);
        pulse_load(16'h1234, 4'b0001);
        run(70);

        // Mid-frame load keeps the current frame; a load on the wrap shows at once.
        run_to(12);
        pulse_load(16'hEEEE, 4'b0000);
        run(60);
        run_to(31);
        pulse_load(16'h5A0C, 4'b1010);
        run(34);

        // Per-digit mask, then a disable in the middle of a slot.
        digit_en = 4'b1010;
        run(40);
        run_to(12);
        enable = 1'b0;
        run(2);
        pulse_load(16'h8888, 4'b1111);
        run(2);
        enable = 1'b1;
        digit_en = 4'b1111;
        run(70);

        // Reset at digit 2, slot count 5, then a '-' frame.
        run_to(21);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        run(5);
        pulse_load(16'hAAAA, 4'b0000);
        run(70);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            enable   = ($urandom_range(0, 9) != 0);
            load     = ($urandom_range(0, 7) == 0);
            data     = 16'($urandom);
            dp_in    = 4'($urandom);
            rst      = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) digit_en = 4'($urandom);
            cycle();
        end
        rst  = 1'b0;
        load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
